// File: rtl/icmp_serial_if.sv
// rtl/icmp_serial_if.sv - operand/result handshake bundle for icmp_serial
//
// Signals:
//   in_valid / in_ready : operand pair handshake (a, b sampled on accept)
//   a, b                : BW-bit operands
//   out_valid/out_ready : result handshake
//   eq ne slt sle sgt sge ult ule ugt uge : comparison flags
// Modports: master = operand producer / result consumer, slave = comparator.
`timescale 1ns/1ps
interface icmp_serial_if #(
  parameter int BW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] a;
  logic [BW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic          eq, ne, slt, sle, sgt, sge, ult, ule, ugt, uge;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, eq, ne, slt, sle, sgt, sge, ult, ule, ugt, uge
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, eq, ne, slt, sle, sgt, sge, ult, ule, ugt, uge
  );
endinterface

// File: rtl/icmp_serial.sv
// rtl/icmp_serial.sv - digit-serial MSB-first integer comparator, ten-flag result
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   io  : icmp_serial_if.slave (in_valid/in_ready/a/b, out_valid/out_ready, flags)
// Parameters: BW operand width (>=2), DIGIT bits scanned per cycle (BW % DIGIT == 0).
// Optional: define ICMP_SERIAL_EARLY_EXIT_EN to finish on the first differing digit.
`timescale 1ns/1ps
module icmp_serial #(
  parameter int BW    = 8,
  parameter int DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  icmp_serial_if.slave  io
);

  localparam int N  = BW / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (BW < 2 || DIGIT < 1 || (BW % DIGIT) != 0) begin : g_bad_params
    $error("icmp_serial: BW must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   a_sh_q, a_sh_d;
  logic [BW-1:0]   b_sh_q, b_sh_d;
  logic            a_sign_q, a_sign_d;
  logic            b_sign_q, b_sign_d;
  logic            decided_q, decided_d;
  logic            lt_u_q, lt_u_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  // {eq, ne, slt, sle, sgt, sge, ult, ule, ugt, uge}
  logic [9:0]      flags_q, flags_d;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             differ;
  logic             dec_nxt, lt_nxt;
  logic             last_digit, exit_now;

  assign dig_a  = a_sh_q[BW-1 -: DIGIT];
  assign dig_b  = b_sh_q[BW-1 -: DIGIT];
  assign differ = (dig_a != dig_b);

  // Only the first differing digit (from the MSB) decides the unsigned order.
  assign dec_nxt    = decided_q | differ;
  assign lt_nxt     = decided_q ? lt_u_q : (differ & (dig_a < dig_b));
  assign last_digit = (cnt_q == CW'(N - 1));

`ifdef ICMP_SERIAL_EARLY_EXIT_EN
  assign exit_now = last_digit | (!decided_q & differ);
`else
  assign exit_now = last_digit;
`endif

  function automatic logic [9:0] derive_flags(input logic dec, input logic lt,
                                              input logic as, input logic bs);
    logic f_eq, f_ult, f_ugt, f_slt, f_sgt;
    f_eq  = !dec;
    f_ult = lt;
    f_ugt = dec & !lt;
    if (as != bs) begin
      // Mixed signs: the negative operand is the smaller one.
      f_slt = as & !bs;
      f_sgt = !f_slt & dec;
    end else begin
      f_slt = f_ult;
      f_sgt = f_ugt;
    end
    return {f_eq, dec, f_slt, f_slt | f_eq, f_sgt, f_sgt | f_eq,
            f_ult, f_ult | f_eq, f_ugt, f_ugt | f_eq};
  endfunction

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    decided_d   = decided_q;
    lt_u_d      = lt_u_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid && in_ready_q) begin
          state_d    = RUN;
          a_sh_d     = io.a;
          b_sh_d     = io.b;
          a_sign_d   = io.a[BW-1];
          b_sign_d   = io.b[BW-1];
          decided_d  = 1'b0;
          lt_u_d     = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        a_sh_d    = a_sh_q << DIGIT;
        b_sh_d    = b_sh_q << DIGIT;
        decided_d = dec_nxt;
        lt_u_d    = lt_nxt;
        cnt_d     = cnt_q + CW'(1);
        if (exit_now) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          flags_d     = derive_flags(dec_nxt, lt_nxt, a_sign_q, b_sign_q);
        end
      end
      DONE: begin
        // Return to IDLE without accepting in the same cycle.
        if (io.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      decided_q   <= 1'b0;
      lt_u_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      decided_q   <= decided_d;
      lt_u_q      <= lt_u_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      flags_q     <= flags_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign {io.eq, io.ne, io.slt, io.sle, io.sgt, io.sge,
          io.ult, io.ule, io.ugt, io.uge} = flags_q;

endmodule
